// File: rtl/stereo_matrix_interp4.sv
// Stereo matrix plus 4x linear interpolator.
// Forms L+R and L-R at the 48 kHz input rate and interpolates both to 192 kHz
// as 2*(prev + ph*(curr-prev)/4). One shared datapath serves both channels:
// the sum channel in CALC_S, then the difference channel in CALC_D.
module stereo_matrix_interp4 #(
    parameter int NIN  = 16,
    parameter int NOUT = NIN + 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enableclk48,
    input  logic                   enableclk192,
    input  logic signed [NIN-1:0]  left,
    input  logic signed [NIN-1:0]  right,
    output logic signed [NOUT-1:0] lpr,
    output logic signed [NOUT-1:0] lmr,
    output logic                   ready,
    output logic                   sync_err
);

    typedef enum logic [1:0] {
        IDLE,
        CALC_S,
        CALC_D
    } state_t;

    state_t state;

    logic signed [NIN:0]   s_prev;
    logic signed [NIN:0]   s_curr;
    logic signed [NIN:0]   d_prev;
    logic signed [NIN:0]   d_curr;
    logic [1:0]            ph;

    logic signed [NIN:0]   sum_in;
    logic signed [NIN:0]   diff_in;
    logic signed [NIN:0]   op_prev;
    logic signed [NIN:0]   op_curr;
    logic signed [NIN+1:0] delta;
    logic signed [NIN+3:0] delta_ext;
    logic signed [NIN+3:0] prev_x4;
    logic signed [NIN+3:0] term_1;
    logic signed [NIN+3:0] term_2;
    logic signed [NIN+3:0] acc;
    logic signed [NOUT-1:0] result;
    logic [1:0]            unused_acc_bits;

    // One extra bit on the sum and difference means neither can overflow.
    assign sum_in  = {left[NIN-1], left} + {right[NIN-1], right};
    assign diff_in = {left[NIN-1], left} - {right[NIN-1], right};

    // Steer the shared datapath to the sum pair in CALC_S and the difference pair otherwise.
    always_comb begin
        op_prev = s_prev;
        op_curr = s_curr;
        if (state == CALC_D) begin
            op_prev = d_prev;
            op_curr = d_curr;
        end
    end

    // acc = 4*prev + ph*delta, with ph*delta built from a shift-and-add on the two phase bits.
    assign delta     = {op_curr[NIN], op_curr} - {op_prev[NIN], op_prev};
    assign delta_ext = {{2{delta[NIN+1]}}, delta};
    assign prev_x4   = {op_prev[NIN], op_prev, 2'b00};
    assign term_1    = ph[0] ? delta_ext : '0;
    assign term_2    = ph[1] ? (delta_ext <<< 1) : '0;
    assign acc       = prev_x4 + term_1 + term_2;

    // Halving by dropping the LSB rounds toward minus infinity; the top bit is pure sign extension.
    assign result          = acc[NIN+2:1];
    assign unused_acc_bits = {acc[NIN+3], acc[0]};

    // Strobe handling, sample history, phase tracking and the two-step output update.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            s_prev   <= '0;
            s_curr   <= '0;
            d_prev   <= '0;
            d_curr   <= '0;
            ph       <= 2'd0;
            lpr      <= '0;
            lmr      <= '0;
            ready    <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (enableclk192 && enableclk48) begin
                        s_prev <= s_curr;
                        s_curr <= sum_in;
                        d_prev <= d_curr;
                        d_curr <= diff_in;
                        ph     <= 2'd0;
                        state  <= CALC_S;
                    end else if (enableclk192 && (ph != 2'd3)) begin
                        ph    <= ph + 2'd1;
                        state <= CALC_S;
                    end else if (enableclk192 || enableclk48) begin
                        sync_err <= 1'b1;
                    end
                end
                CALC_S: begin
                    lpr   <= result;
                    state <= CALC_D;
                    if (enableclk192 || enableclk48) begin
                        sync_err <= 1'b1;
                    end
                end
                CALC_D: begin
                    lmr   <= result;
                    ready <= 1'b1;
                    state <= IDLE;
                    if (enableclk192 || enableclk48) begin
                        sync_err <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stereo_matrix_interp4.sv
// Bench for stereo_matrix_interp4: directed strobe sequences, a sample-level
// interpolation model checked on every cycle, and literal spot values.
module tb_stereo_matrix_interp4;

    logic               clock = 1'b0;
    logic               reset;
    logic               enableclk48;
    logic               enableclk192;
    logic signed [15:0] left;
    logic signed [15:0] right;
    logic signed [17:0] lpr;
    logic signed [17:0] lmr;
    logic               ready;
    logic               sync_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model state: 48 kHz sample history of the sum and difference, and the current phase.
    int m_s_prev, m_s_curr, m_d_prev, m_d_curr, m_ph;
    int m_err;
    int pend_valid, pend_cyc, pend_lpr, pend_lmr;
    int last_lpr, last_lmr;

    int ramp_a[4] = '{0, 200, 400, 600};
    int ramp_b[4] = '{800, 1000, 1200, 1400};

    stereo_matrix_interp4 dut (
        .clock        (clock),
        .reset        (reset),
        .enableclk48  (enableclk48),
        .enableclk192 (enableclk192),
        .left         (left),
        .right        (right),
        .lpr          (lpr),
        .lmr          (lmr),
        .ready        (ready),
        .sync_err     (sync_err)
    );

    // Free-running system clock.
    always #5 clock = ~clock;

    // 2*(p + k*(c-p)/4), rounded toward minus infinity.
    function automatic int interp(input int p, input int c, input int k);
        int num;
        num = 4 * p + k * (c - p);
        if (num < 0 && (num % 2) != 0) return (num - 1) / 2;
        return num / 2;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic model_reset();
        m_s_prev = 0; m_s_curr = 0; m_d_prev = 0; m_d_curr = 0; m_ph = 0;
        m_err = 0;
        pend_valid = 0; pend_cyc = 0; pend_lpr = 0; pend_lmr = 0;
        last_lpr = 0; last_lmr = 0;
    endtask

    // Drive one clock of stimulus, advance the model at the edge, compare at the falling edge.
    task automatic applyStimulus(input bit e48, input bit e192, input int l, input int r);
        int busy, accept, d, exp_lpr, exp_lmr, exp_rdy;
        enableclk48  = e48;
        enableclk192 = e192;
        left         = 16'(l);
        right        = 16'(r);
        @(posedge clock);
        cyc++;
        busy   = (pend_valid != 0) && (cyc - pend_cyc) >= 1 && (cyc - pend_cyc) <= 2;
        accept = 0;
        if ((e48 || e192) && busy) begin
            m_err = 1;
        end else if (e48 && e192) begin
            m_s_prev = m_s_curr; m_s_curr = l + r;
            m_d_prev = m_d_curr; m_d_curr = l - r;
            m_ph = 0;
            accept = 1;
        end else if (e192 && m_ph < 3) begin
            m_ph++;
            accept = 1;
        end else if (e192 || e48) begin
            m_err = 1;
        end
        if (accept != 0) begin
            if (pend_valid != 0) begin
                last_lpr = pend_lpr;
                last_lmr = pend_lmr;
            end
            pend_lpr   = interp(m_s_prev, m_s_curr, m_ph);
            pend_lmr   = interp(m_d_prev, m_d_curr, m_ph);
            pend_cyc   = cyc;
            pend_valid = 1;
        end
        @(negedge clock);
        exp_lpr = last_lpr;
        exp_lmr = last_lmr;
        exp_rdy = 0;
        if (pend_valid != 0) begin
            d = cyc - pend_cyc;
            if (d == 1) begin
                exp_lpr = pend_lpr;
            end else if (d >= 2) begin
                exp_lpr = pend_lpr;
                exp_lmr = pend_lmr;
                exp_rdy = (d == 2) ? 1 : 0;
            end
        end
        checkOutput("lpr", int'(lpr), exp_lpr);
        checkOutput("lmr", int'(lmr), exp_lmr);
        checkOutput("ready", int'(ready), exp_rdy);
        checkOutput("sync_err", int'(sync_err), m_err);
    endtask

    task automatic frame(input int l, input int r);
        applyStimulus(1'b1, 1'b1, l, r);
        repeat (3) applyStimulus(1'b0, 1'b0, l, r);
    endtask

    task automatic sub(input int l, input int r);
        applyStimulus(1'b0, 1'b1, l, r);
        repeat (3) applyStimulus(1'b0, 1'b0, l, r);
    endtask

    task automatic period(input int l, input int r);
        frame(l, r);
        repeat (3) sub(l, r);
    endtask

    // Directed scenarios in sequence, then the summary.
    initial begin
        reset        = 1'b0;
        enableclk48  = 1'b0;
        enableclk192 = 1'b0;
        left         = '0;
        right        = '0;
        model_reset();
        repeat (3) @(negedge clock);
        checkOutput("reset_lpr", int'(lpr), 0);
        checkOutput("reset_lmr", int'(lmr), 0);
        checkOutput("reset_ready", int'(ready), 0);
        checkOutput("reset_sync_err", int'(sync_err), 0);
        reset = 1'b1;

        // Constant input
        period(1000, 200);
        frame(1000, 200);
        checkOutput("const_lpr", int'(lpr), 2400);
        checkOutput("const_lmr", int'(lmr), 1600);
        repeat (3) sub(1000, 200);
        checkOutput("const_lpr_ph3", int'(lpr), 2400);
        checkOutput("const_lmr_ph3", int'(lmr), 1600);

        // Ramp
        period(0, 0);
        frame(400, 0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) sub(400, 0);
            checkOutput("ramp_lpr", int'(lpr), ramp_a[k]);
            checkOutput("ramp_lmr", int'(lmr), ramp_a[k]);
        end
        frame(800, 0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) sub(800, 0);
            checkOutput("ramp2_lpr", int'(lpr), ramp_b[k]);
        end

        // Full scale
        period(32767, 32767);
        frame(32767, 32767);
        checkOutput("fs_lpr", int'(lpr), 131068);
        checkOutput("fs_lmr", int'(lmr), 0);
        repeat (3) sub(32767, 32767);
        period(-32768, 32767);
        frame(-32768, 32767);
        checkOutput("fs_lmr_min", int'(lmr), -131070);
        checkOutput("fs_lpr_neg", int'(lpr), -2);
        repeat (3) sub(-32768, 32767);

        // Rounding toward minus infinity
        period(0, 0);
        frame(-1, 0);
        checkOutput("round_lpr_ph0", int'(lpr), 0);
        sub(-1, 0);
        checkOutput("round_lpr_ph1", int'(lpr), -1);

        // Missing 48 kHz strobe
        sub(-1, 0);
        sub(-1, 0);
        checkOutput("miss_sync_err_before", int'(sync_err), 0);
        sub(-1, 0);
        checkOutput("miss_sync_err", int'(sync_err), 1);
        checkOutput("miss_lpr_hold", int'(lpr), -2);
        checkOutput("miss_lmr_hold", int'(lmr), -2);
        frame(300, 100);
        sub(300, 100);
        checkOutput("resume_lpr_ph1", int'(lpr), 198);
        checkOutput("resume_lmr_ph1", int'(lmr), 98);
        sub(300, 100);
        sub(300, 100);

        // Strobe collision one cycle after an accepted strobe
        applyStimulus(1'b1, 1'b1, 500, 100);
        applyStimulus(1'b0, 1'b1, 500, 100);
        repeat (3) applyStimulus(1'b0, 1'b0, 500, 100);
        checkOutput("coll_lpr", int'(lpr), 800);
        checkOutput("coll_lmr", int'(lmr), 400);
        sub(500, 100);
        checkOutput("coll_lpr_ph1", int'(lpr), 900);
        checkOutput("coll_lmr_ph1", int'(lmr), 500);

        // Reset while the sum channel is being computed
        applyStimulus(1'b1, 1'b1, 1000, 200);
        enableclk48  = 1'b0;
        enableclk192 = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("midrst_lpr", int'(lpr), 0);
        checkOutput("midrst_lmr", int'(lmr), 0);
        checkOutput("midrst_ready", int'(ready), 0);
        checkOutput("midrst_sync_err", int'(sync_err), 0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        frame(1000, 200);
        checkOutput("post_rst_lpr", int'(lpr), 0);
        checkOutput("post_rst_lmr", int'(lmr), 0);
        sub(1000, 200);
        checkOutput("post_rst_lpr_ph1", int'(lpr), 600);
        checkOutput("post_rst_lmr_ph1", int'(lmr), 400);
        checkOutput("post_rst_sync_err", int'(sync_err), 0);

        // 48 kHz strobe without the 192 kHz strobe
        applyStimulus(1'b1, 1'b0, 1000, 200);
        checkOutput("lone48_sync_err", int'(sync_err), 1);
        repeat (3) applyStimulus(1'b0, 1'b0, 1000, 200);
        checkOutput("lone48_lpr_hold", int'(lpr), 600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
